// File: rtl/store_buffer_if.sv
// ----------------------------------------------------------------------------
// store_buffer_if
//   Groups the store, load, flush, status and data_memory signals of the store
//   buffer into one bundle.
//   master : MEM pipeline stage side (drives stores, loads and flush requests,
//            observes ready/stall/forwarding/status and the memory request).
//   slave  : the store buffer itself.
// ----------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_stall;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_fwd_data;
  logic              flush_req;
  logic              flush_done;
  logic              empty;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, flush_req,
    input  st_ready, ld_stall, ld_hit, ld_fwd_data, flush_done, empty,
           mem_read_en, mem_write_en, mem_addr, mem_write_data
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, flush_req,
    output st_ready, ld_stall, ld_hit, ld_fwd_data, flush_done, empty,
           mem_read_en, mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//   Posted-write FIFO between the MEM stage and data_memory. Stores are taken
//   in one cycle and drained to memory in cycles without a load (or every
//   cycle when full or flushing). Loads go to memory directly unless they hit
//   a buffered store, in which case the youngest matching data is forwarded.
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; discards all buffered stores
//   bus   : store_buffer_if.slave (store/load/flush handshake, status,
//           data_memory request)
// ----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  store_buffer_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  logic [ADDR_W-1:0] ent_addr_r [DEPTH];
  logic [DATA_W-1:0] ent_data_r [DEPTH];
  logic [DEPTH-1:0]  ent_valid_r;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  state_t            state_r;
  state_t            state_s;

  logic              full_s;
  logic              ready_s;
  logic              push_s;
  logic              drain_s;
  logic              match_s;
  logic              hit_s;
  logic              read_s;
  logic              flush_done_s;
  logic [DATA_W-1:0] match_data_s;

  // Forwarding search: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = head_r;
    match_s      = 1'b0;
    match_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_r + PTR_W'(i);
      if (ent_valid_r[idx] &&
          (ent_addr_r[idx][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2])) begin
        match_s      = 1'b1;
        match_data_s = ent_data_r[idx];
      end else begin
        match_s      = match_s;
      end
    end
  end

  // Handshake, drain slot and memory request steering.
  always_comb begin
    full_s  = (count_r == CNT_FULL);
    // Readiness uses the pre-edge count, so a full buffer that pops this
    // cycle still refuses a new store.
    ready_s = !full_s && (state_r != FLUSH);
    push_s  = bus.st_valid && ready_s;
    drain_s = (count_r != '0) &&
              (!bus.ld_valid || full_s || (state_r == FLUSH));
    hit_s   = bus.ld_valid && match_s;
    // A hit never touches memory, so it may complete during a drain.
    read_s  = bus.ld_valid && !drain_s && !hit_s;

    bus.st_ready     = ready_s;
    bus.ld_stall     = bus.ld_valid && drain_s && !hit_s;
    bus.ld_hit       = hit_s;
    bus.ld_fwd_data  = hit_s ? match_data_s : '0;
    bus.empty        = (count_r == '0);
    bus.flush_done   = flush_done_s;
    bus.mem_write_en = drain_s;
    bus.mem_read_en  = read_s;
    if (drain_s) begin
      bus.mem_addr       = ent_addr_r[head_r];
      bus.mem_write_data = ent_data_r[head_r];
    end else if (read_s) begin
      bus.mem_addr       = bus.ld_addr;
      bus.mem_write_data = '0;
    end else begin
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
    end
  end

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      ent_valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_r[i] <= '0;
        ent_data_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        ent_addr_r[tail_r]  <= bus.st_addr;
        ent_data_r[tail_r]  <= bus.st_data;
        ent_valid_r[tail_r] <= 1'b1;
        tail_r              <= tail_r + PTR_ONE;
      end
      // Push and pop never address the same slot: both require 0<count<DEPTH.
      if (drain_s) begin
        ent_valid_r[head_r] <= 1'b0;
        head_r              <= head_r + PTR_ONE;
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; flush completes on the first FLUSH cycle with no entries.
  always_comb begin
    state_s      = state_r;
    flush_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.flush_req) begin
          state_s = FLUSH;
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH: begin
        if (count_r == '0) begin
          state_s      = IDLE;
          flush_done_s = 1'b1;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
// ----------------------------------------------------------------------------
// tb_store_buffer
//   Directed scenarios followed by random traffic. A queue-based reference
//   model predicts every output each cycle; expected memory writes are queued
//   when a store is accepted and popped by an independent write monitor.
// ----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   done_seen = 0;
  ent_t m_q[$];     // reference model contents, index 0 = oldest
  bit   m_flush = 1'b0;
  ent_t wr_q[$];    // scoreboard: expected memory writes in order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write monitor: every DUT memory write must match the oldest expected one.
  always @(negedge clk) begin
    ent_t e;
    if (!reset && bus.mem_write_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected_write: got addr %0h data %0h expected no write",
                 bus.mem_addr, bus.mem_write_data);
      end else begin
        e = wr_q.pop_front();
        chk("sb_wr_addr", bus.mem_addr, e.a);
        chk("sb_wr_data", bus.mem_write_data, e.d);
      end
    end
  end

  // One clock cycle: drive inputs, check all outputs against the model, commit.
  task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic fr);
    int n;
    bit full, rdy, push, drain, found, hit, stall, rd, fdone;
    logic [31:0] fd, ea, ewd;
    ent_t ne;
    bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd;
    bus.ld_valid = lv; bus.ld_addr = la; bus.flush_req = fr;
    #1;
    n     = m_q.size();
    full  = (n == DEPTH);
    rdy   = !full && !m_flush;
    push  = sv && rdy;
    drain = (n > 0) && (!lv || full || m_flush);
    found = 1'b0;
    fd    = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      if (m_q[i].a[31:2] == la[31:2]) begin
        found = 1'b1;
        fd    = m_q[i].d;
        break;
      end
    end
    hit   = lv && found;
    stall = lv && drain && !hit;
    rd    = lv && !drain && !hit;
    fdone = m_flush && (n == 0);
    ea    = 32'h0;
    ewd   = 32'h0;
    if (drain) begin
      ea  = m_q[0].a;
      ewd = m_q[0].d;
    end else if (rd) begin
      ea = la;
    end
    chk("st_ready", bus.st_ready, rdy);
    chk("mem_write_en", bus.mem_write_en, drain);
    chk("mem_read_en", bus.mem_read_en, rd);
    chk("ld_hit", bus.ld_hit, hit);
    chk("ld_fwd_data", bus.ld_fwd_data, hit ? fd : 32'h0);
    chk("ld_stall", bus.ld_stall, stall);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_write_data", bus.mem_write_data, ewd);
    chk("empty", bus.empty, n == 0);
    chk("flush_done", bus.flush_done, fdone);
    if (bus.flush_done === 1'b1) done_seen++;
    if (push) begin
      ne.a = sa;
      ne.d = sd;
      wr_q.push_back(ne);
    end
    @(posedge clk);
    if (drain) void'(m_q.pop_front());
    if (push) m_q.push_back(ne);
    if (m_flush) begin
      if (n == 0) m_flush = 1'b0;
    end else if (fr) begin
      m_flush = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    bus.st_valid = 1'b0; bus.st_addr = 32'h0; bus.st_data = 32'h0;
    bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.flush_req = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_st_ready", bus.st_ready, 1'b1);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_flush_done", bus.flush_done, 1'b0);
    chk("rst_mem_write_en", bus.mem_write_en, 1'b0);
    chk("rst_mem_read_en", bus.mem_read_en, 1'b0);
    chk("rst_ld_stall", bus.ld_stall, 1'b0);
    chk("rst_ld_hit", bus.ld_hit, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    m_q.delete();
    wr_q.delete();
    m_flush = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain_all();
    for (int k = 0; k < 20 && (m_q.size() != 0 || m_flush); k++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    if (m_q.size() != 0 || m_flush) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", m_q.size());
    end
  endtask

  localparam logic [31:0] MISS = 32'h300;

  initial begin
    bus.st_valid = 1'b0; bus.st_addr = 32'h0; bus.st_data = 32'h0;
    bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.flush_req = 1'b0;
    #1;
    do_reset();

    // Single store drains the following cycle.
    cycle(1'b1, 32'h10, 32'hAA, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Two stores to one address; the younger one is forwarded.
    cycle(1'b1, 32'h20, 32'h1, 1'b1, MISS, 1'b0);
    cycle(1'b1, 32'h20, 32'h2, 1'b1, MISS, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h22, 1'b0);
    drain_all();

    // Fill with loads pending, then a miss load sees forced drain and stall.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h40 + 32'(i * 4), 32'hB0 + 32'(i), 1'b1, MISS, 1'b0);
    cycle(1'b1, 32'h50, 32'hBF, 1'b1, MISS, 1'b0);
    cycle(1'b1, 32'h50, 32'hBF, 1'b1, 32'h44, 1'b0);
    drain_all();

    // Hold two entries, then push and pop together across the pointer wrap.
    cycle(1'b1, 32'h60, 32'hC0, 1'b1, MISS, 1'b0);
    cycle(1'b1, 32'h64, 32'hC1, 1'b1, MISS, 1'b0);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h68 + 32'(i * 4), 32'hC2 + 32'(i), 1'b0, 32'h0, 1'b0);
    drain_all();

    // Three stores then a flush with loads held high.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h80 + 32'(i * 4), 32'hD0 + 32'(i), 1'b1, MISS, 1'b0);
    done_seen = 0;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, MISS, 1'b1);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h90, 32'hDD, 1'b1, MISS, 1'b0);
    chk("flush_done_pulses", done_seen, 1);
    drain_all();

    // Flush of an already empty buffer.
    done_seen = 0;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("flush_empty_pulses", done_seen, 1);

    // Reset with two entries pending discards them.
    cycle(1'b1, 32'hA0, 32'hE0, 1'b1, MISS, 1'b0);
    cycle(1'b1, 32'hA4, 32'hE1, 1'b1, MISS, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Random traffic over a small address window to provoke hits.
    for (int i = 0; i < 400; i++) begin
      logic sv, lv, fr;
      logic [31:0] sa, la, sd;
      sv = ($urandom_range(0, 9) < 6);
      lv = ($urandom_range(0, 9) < 5);
      fr = ($urandom_range(0, 19) == 0);
      sa = 32'h100 + 32'($urandom_range(0, 7) * 4);
      la = 32'h100 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
      sd = $urandom;
      cycle(sv, sa, sd, lv, la, fr);
    end
    drain_all();
    chk("sb_leftover", wr_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
